ps2_scancode_parser: RTL

PS2_SCANCODE_PARSER -- requirements
Module: ps2_scancode_parser

---
 rtl/ps2_scancode_parser.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_parser.sv
// ps2_scancode_parser
//
// Turns the raw PS/2 set-2 byte stream from an upstream byte decoder into
// key events {ext, brk, code} and buffers them in a first-word-fall-through
// event FIFO that the host drains.
//
// Optional feature macro: PS2_PAUSE_SEQ_EN
//   defined   : E1 in IDLE starts the 8-byte Pause sequence, which collapses
//               into one event {ext=1, brk=0, code=0x77}.
//   undefined : E1 is discarded in every state and the following bytes are
//               parsed as ordinary scancodes.
//
// Parameters
//   FIFO_DEPTH  event FIFO depth, power of two in 2..16 (default 8)
//
// Ports
//   clk         system clock, all state changes on its rising edge
//   reset       asynchronous active-high reset
//   byte_valid  one-cycle strobe qualifying byte_data
//   byte_data   received scancode byte
//   rd_pop      host pops the head event (one per cycle while high)
//   ovf_clear   clears the sticky overflow flag
//   VPWR, VGND  power rails, no logic attached
//   evt_code    head event base scancode (0 when empty)
//   evt_ext     head event had an E0 prefix (0 when empty)
//   evt_break   head event is a release (0 when empty)
//   evt_avail   FIFO not empty, level interrupt to the host
//   fifo_count  number of stored events, 0..FIFO_DEPTH
//   overflow    sticky: an event was dropped on a full FIFO
module ps2_scancode_parser #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       rd_pop,
  input  logic       ovf_clear,
  inout  wire        VPWR,
  inout  wire        VGND,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_avail,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int         PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH_CNT = 5'(FIFO_DEPTH);

  // Rails are only routed through the port list; nothing is computed from them.
  logic [1:0] unused_rails_s;
  assign unused_rails_s = {VPWR, VGND};

`ifdef PS2_PAUSE_SEQ_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PFX_E0   = 3'd1,
    PFX_F0   = 3'd2,
    PFX_E0F0 = 3'd3,
    SKIP_E1  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PFX_E0   = 3'd1,
    PFX_F0   = 3'd2,
    PFX_E0F0 = 3'd3
  } state_t;
`endif

  state_t state_r, state_next_s;

`ifdef PS2_PAUSE_SEQ_EN
  // Counts the 7 bytes that follow E1 in the Pause sequence.
  logic [2:0] skip_cnt_r, skip_cnt_next_s;
`endif

  logic       emit_s;
  logic       emit_ext_s;
  logic       emit_brk_s;
  logic [7:0] emit_code_s;

  // FIFO storage and bookkeeping
  logic [9:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_r, rd_ptr_next_s;
  logic [PTR_W-1:0] wr_ptr_r, wr_ptr_next_s;
  logic [4:0]       count_r, count_next_s;
  logic [9:0]       head_r, head_next_s;
  logic             avail_r;
  logic             ovf_r, ovf_next_s;
  logic             pop_ok_s, push_ok_s, drop_s, full_s;
  logic [9:0]       entry_s;

  // Parser state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

`ifdef PS2_PAUSE_SEQ_EN
  // Pause-sequence byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_cnt_r <= 3'd0;
    end else begin
      skip_cnt_r <= skip_cnt_next_s;
    end
  end
`endif

  // Parser next state and event emission; advances only on byte_valid.
  always_comb begin
    state_next_s = state_r;
    emit_s       = 1'b0;
    emit_ext_s   = 1'b0;
    emit_brk_s   = 1'b0;
    emit_code_s  = byte_data;
`ifdef PS2_PAUSE_SEQ_EN
    skip_cnt_next_s = skip_cnt_r;
`endif
    if (byte_valid) begin
      case (state_r)
        IDLE: begin
          case (byte_data)
            8'hE0: state_next_s = PFX_E0;
            8'hF0: state_next_s = PFX_F0;
            8'h00: state_next_s = IDLE;   // keyboard error, dropped
            8'hFF: state_next_s = IDLE;   // keyboard overrun, dropped
`ifdef PS2_PAUSE_SEQ_EN
            8'hE1: begin
              state_next_s    = SKIP_E1;
              skip_cnt_next_s = 3'd0;
            end
`else
            8'hE1: state_next_s = IDLE;
`endif
            default: begin
              emit_s = 1'b1;
            end
          endcase
        end
        PFX_E0: begin
          case (byte_data)
            8'hF0: state_next_s = PFX_E0F0;
            8'hE0: state_next_s = PFX_E0;
            8'hE1: state_next_s = PFX_E0;   // discarded, prefix kept
            default: begin
              emit_s       = 1'b1;
              emit_ext_s   = 1'b1;
              state_next_s = IDLE;
            end
          endcase
        end
        PFX_F0: begin
          if (byte_data == 8'hE1) begin
            state_next_s = PFX_F0;
          end else begin
            emit_s       = 1'b1;
            emit_brk_s   = 1'b1;
            state_next_s = IDLE;
          end
        end
        PFX_E0F0: begin
          if (byte_data == 8'hE1) begin
            state_next_s = PFX_E0F0;
          end else begin
            emit_s       = 1'b1;
            emit_ext_s   = 1'b1;
            emit_brk_s   = 1'b1;
            state_next_s = IDLE;
          end
        end
`ifdef PS2_PAUSE_SEQ_EN
        SKIP_E1: begin
          // Seventh byte after E1 closes the sequence.
          if (skip_cnt_r == 3'd6) begin
            emit_s          = 1'b1;
            emit_ext_s      = 1'b1;
            emit_code_s     = 8'h77;
            skip_cnt_next_s = 3'd0;
            state_next_s    = IDLE;
          end else begin
            skip_cnt_next_s = skip_cnt_r + 3'd1;
          end
        end
`endif
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FIFO control: push/pop arbitration, pointers, count, and the next head.
  always_comb begin
    entry_s   = {emit_ext_s, emit_brk_s, emit_code_s};
    full_s    = (count_r == DEPTH_CNT);
    pop_ok_s  = rd_pop && (count_r != 5'd0);
    push_ok_s = emit_s && (!full_s || pop_ok_s);
    drop_s    = emit_s && full_s && !pop_ok_s;

    rd_ptr_next_s = rd_ptr_r;
    wr_ptr_next_s = wr_ptr_r;
    count_next_s  = count_r;
    head_next_s   = 10'd0;

    if (pop_ok_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    if (push_ok_s) begin
      wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + 5'd1;
      2'b01:   count_next_s = count_r - 5'd1;
      default: count_next_s = count_r;
    endcase

    // The head register is loaded ahead of time so outputs stay registered;
    // when the new head is the slot being written this cycle, bypass the write.
    if (count_next_s == 5'd0) begin
      head_next_s = 10'd0;
    end else if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
      head_next_s = entry_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end

    // A drop wins over a simultaneous clear so no loss goes unreported.
    if (drop_s) begin
      ovf_next_s = 1'b1;
    end else if (ovf_clear) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf_r;
    end
  end

  // Event storage write port (contents are don't-care until pointed to).
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // FIFO bookkeeping and registered output state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= 5'd0;
      head_r   <= 10'd0;
      avail_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      rd_ptr_r <= rd_ptr_next_s;
      wr_ptr_r <= wr_ptr_next_s;
      count_r  <= count_next_s;
      head_r   <= head_next_s;
      avail_r  <= (count_next_s != 5'd0);
      ovf_r    <= ovf_next_s;
    end
  end

  assign evt_code   = head_r[7:0];
  assign evt_break  = head_r[8];
  assign evt_ext    = head_r[9];
  assign evt_avail  = avail_r;
  assign fifo_count = count_r;
  assign overflow   = ovf_r;

endmodule
